// File: rtl/unpool_stream.sv
// unpool_stream
//   Streaming unpooling stage for the CNN decoder path. Coarse pixels arrive
//   one at a time, are collected into one of two ping-pong line buffers, and
//   each completed coarse line is replayed 2^SCALE_LOG2 times horizontally and
//   vertically to produce the full-resolution raster.
//   Modes: 0 = nearest replicate, 1 (and 3) = zero-insert,
//          2 = indexed max-unpool using the index from the max-pool stage.
//
// Ports
//   clock, n_rst            single clock, asynchronous active-low reset
//   mode                    unpool mode, latched on the first pixel of a frame
//   in_valid / in_ready     input handshake
//   in_pixels               coarse pixel, channel 0 in the MSBs
//   in_index                {row_off, col_off} of the max position (mode 2 only)
//   out_valid / out_ready   output handshake
//   out_pixels              full-resolution pixel (zero while out_valid is low)
//   out_vcnt / out_hcnt     output row / column of the pixel being presented
//   out_eof                 last pixel of the frame
//
// SCALE_LOG2 is meant to stay in 1..3; IN_WIDTH and IN_HEIGHT must be >= 2.
module unpool_stream #(
   parameter int IN_WIDTH   = 40,
   parameter int IN_HEIGHT  = 30,
   parameter int FIXED_BITW = 16,
   parameter int UNITS      = 4,
   parameter int SCALE_LOG2 = 1,
   localparam int IDX_BITW  = 2 * SCALE_LOG2,
   localparam int V_BITW    = $clog2(IN_HEIGHT << SCALE_LOG2),
   localparam int H_BITW    = $clog2(IN_WIDTH << SCALE_LOG2),
   localparam int PIX_BITW  = FIXED_BITW * UNITS
) (
   input  logic                clock,
   input  logic                n_rst,
   input  logic [1:0]          mode,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [0:PIX_BITW-1] in_pixels,
   input  logic [IDX_BITW-1:0] in_index,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [0:PIX_BITW-1] out_pixels,
   output logic [V_BITW-1:0]   out_vcnt,
   output logic [H_BITW-1:0]   out_hcnt,
   output logic                out_eof
);

   localparam int S    = SCALE_LOG2;
   localparam int WC_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
   localparam int WR_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
   localparam logic [WC_W-1:0]   WCOL_MAX = WC_W'(IN_WIDTH - 1);
   localparam logic [WR_W-1:0]   ROW_MAX  = WR_W'(IN_HEIGHT - 1);
   localparam logic [H_BITW-1:0] OX_MAX   = H_BITW'((IN_WIDTH << S) - 1);
   localparam logic [S-1:0]      SY_MAX   = {S{1'b1}};

   // Line buffers: pixel, index and the mode of the frame each line belongs to
   logic [0:PIX_BITW-1] pix_mem_r [2][IN_WIDTH];
   logic [IDX_BITW-1:0] idx_mem_r [2][IN_WIDTH];
   logic [1:0]          bmode_r   [2];
   logic [1:0]          full_r;

   // Write side
   logic            wbuf_r;
   logic [WC_W-1:0] wcol_r;
   logic [WR_W-1:0] wrow_r;
   logic [1:0]      frame_mode_r;

   // Read side
   logic              rbuf_r;
   logic [H_BITW-1:0] ox_r;
   logic [S-1:0]      sy_r;
   logic [WR_W-1:0]   ry_r;
   logic [V_BITW-1:0] vcnt_r;

   logic                in_ready_s, out_valid_s;
   logic                in_hs_s, out_hs_s;
   logic                wlast_s, olast_s, sylast_s, rylast_s;
   logic [1:0]          mode_in_s;
   logic [1:0]          full_set_s, full_clr_s;
   logic [WC_W-1:0]     rd_col_s;
   logic [S-1:0]        col_off_s;
   logic [0:PIX_BITW-1] src_pix_s, out_pix_s;
   logic [IDX_BITW-1:0] src_idx_s;

   assign in_ready_s  = ~full_r[wbuf_r];
   assign out_valid_s = full_r[rbuf_r];

   // Handshakes, line-end detection, frame mode selection and full-flag updates
   always_comb begin
      in_hs_s    = in_valid & in_ready_s;
      out_hs_s   = out_valid_s & out_ready;
      wlast_s    = (wcol_r == WCOL_MAX);
      olast_s    = (ox_r == OX_MAX);
      sylast_s   = (sy_r == SY_MAX);
      rylast_s   = (ry_r == ROW_MAX);
      full_set_s = 2'b00;
      full_clr_s = 2'b00;
      // The first pixel of a frame carries the mode for the whole frame
      if ((wrow_r == {WR_W{1'b0}}) && (wcol_r == {WC_W{1'b0}})) begin
         mode_in_s = mode;
      end else begin
         mode_in_s = frame_mode_r;
      end
      if (in_hs_s && wlast_s) begin
         full_set_s[wbuf_r] = 1'b1;
      end else begin
         full_set_s = 2'b00;
      end
      if (out_hs_s && olast_s && sylast_s) begin
         full_clr_s[rbuf_r] = 1'b1;
      end else begin
         full_clr_s = 2'b00;
      end
   end

   // Output pixel selection from the buffer being replayed
   always_comb begin
      rd_col_s  = WC_W'(ox_r >> S);
      col_off_s = ox_r[S-1:0];
      src_pix_s = pix_mem_r[rbuf_r][rd_col_s];
      src_idx_s = idx_mem_r[rbuf_r][rd_col_s];
      out_pix_s = {PIX_BITW{1'b0}};
      if (!out_valid_s) begin
         out_pix_s = {PIX_BITW{1'b0}};
      end else begin
         case (bmode_r[rbuf_r])
            2'd0: out_pix_s = src_pix_s;
            2'd2: begin
               if ({sy_r, col_off_s} == src_idx_s) begin
                  out_pix_s = src_pix_s;
               end else begin
                  out_pix_s = {PIX_BITW{1'b0}};
               end
            end
            default: begin
               // Zero-insert keeps only the top-left pixel of each block
               if ((sy_r == {S{1'b0}}) && (col_off_s == {S{1'b0}})) begin
                  out_pix_s = src_pix_s;
               end else begin
                  out_pix_s = {PIX_BITW{1'b0}};
               end
            end
         endcase
      end
   end

   // Buffer full flags; set and clear always target different buffers
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         full_r <= 2'b00;
      end else begin
         full_r <= (full_r | full_set_s) & ~full_clr_s;
      end
   end

   // Write side: store accepted pixels and advance the write position
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         for (int b = 0; b < 2; b++) begin
            bmode_r[b] <= 2'd0;
            for (int i = 0; i < IN_WIDTH; i++) begin
               pix_mem_r[b][i] <= {PIX_BITW{1'b0}};
               idx_mem_r[b][i] <= {IDX_BITW{1'b0}};
            end
         end
         wbuf_r       <= 1'b0;
         wcol_r       <= {WC_W{1'b0}};
         wrow_r       <= {WR_W{1'b0}};
         frame_mode_r <= 2'd0;
      end else if (in_hs_s) begin
         pix_mem_r[wbuf_r][wcol_r] <= in_pixels;
         idx_mem_r[wbuf_r][wcol_r] <= in_index;
         bmode_r[wbuf_r]           <= mode_in_s;
         frame_mode_r              <= mode_in_s;
         if (wlast_s) begin
            wcol_r <= {WC_W{1'b0}};
            wbuf_r <= ~wbuf_r;
            if (wrow_r == ROW_MAX) begin
               wrow_r <= {WR_W{1'b0}};
            end else begin
               wrow_r <= wrow_r + WR_W'(1);
            end
         end else begin
            wcol_r <= wcol_r + WC_W'(1);
         end
      end
   end

   // Read side: walk columns, replay the line for each sub-row, then release it
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         rbuf_r <= 1'b0;
         ox_r   <= {H_BITW{1'b0}};
         sy_r   <= {S{1'b0}};
         ry_r   <= {WR_W{1'b0}};
         vcnt_r <= {V_BITW{1'b0}};
      end else if (out_hs_s) begin
         if (olast_s) begin
            ox_r <= {H_BITW{1'b0}};
            if (sylast_s) begin
               sy_r   <= {S{1'b0}};
               rbuf_r <= ~rbuf_r;
               if (rylast_s) begin
                  ry_r   <= {WR_W{1'b0}};
                  vcnt_r <= {V_BITW{1'b0}};
               end else begin
                  ry_r   <= ry_r + WR_W'(1);
                  vcnt_r <= vcnt_r + V_BITW'(1);
               end
            end else begin
               sy_r   <= sy_r + S'(1);
               vcnt_r <= vcnt_r + V_BITW'(1);
            end
         end else begin
            ox_r <= ox_r + H_BITW'(1);
         end
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_s;
   assign out_pixels = out_pix_s;
   assign out_vcnt   = vcnt_r;
   assign out_hcnt   = ox_r;
   assign out_eof    = out_valid_s & rylast_s & sylast_s & olast_s;

endmodule
